lfsr_encrypt_engine: RTL and testbench

- Hardware encryptor (Program 1 direction) for the message/LFSR scheme that the Program 2 decryptor reverses.
- Sits beside data memory (DM) under top_level. Reads the plaintext message and the three config bytes, then writes 64 encrypted, parity-tagged bytes to DM[64..127].
- Uses the same clk/init/req/ack control interface as the program cores.

---
 rtl/lfsr_encrypt_engine.sv | 167 ++++++++++++++++
 tb/tb_lfsr_encrypt_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_encrypt_engine.sv
// lfsr_encrypt_engine
//
// Encrypts the plaintext message held in data memory (DM) with a 7-bit LFSR
// keystream. The results are 64 parity-tagged ciphertext bytes written to
// DM[OUT_BASE .. OUT_BASE+NUM_CHARS-1].
//
// DM layout read by the engine:
//   DM[MSG_BASE .. MSG_BASE+MSG_MAX-1]  message bytes
//   DM[PRE_ADDR]                        pre_length (low 6 bits used)
//   DM[TAP_ADDR]                        LFSR tap pattern (low 7 bits)
//   DM[SEED_ADDR]                       LFSR start state (low 7 bits)
//
// Ports:
//   clk         system clock, all state on the rising edge
//   init        synchronous active-high reset, aborts a run at any time
//   req         held high while idle; a 1->0 transition starts a run
//   ack         registered run-complete flag
//   dm_addr     DM address (read address, or write address when dm_wr_en=1)
//   dm_rd_data  DM read data, combinational read of dm_addr
//   dm_wr_en    single-cycle DM write strobe
//   dm_wr_data  DM write data
//
// Handshake: req idles high. The engine registers req and starts when it sees
// the registered copy high while the live value is low. req is ignored for the
// rest of the run. When all bytes are written, ack rises and stays high until
// req is sampled high again; on that edge the engine returns to IDLE and ack
// drops. Another run needs another 1->0 transition on req.
//
// Optional build macro: LFSR_ZERO_SEED_GUARD_EN
//   When defined, a zero seed is replaced by 7'h01 so the LFSR cannot lock up.
//   When undefined, a zero seed is used as-is (keystream stays zero).

module lfsr_encrypt_engine #(
  parameter int         MSG_BASE  = 0,
  parameter int         MSG_MAX   = 61,
  parameter int         PRE_ADDR  = 61,
  parameter int         TAP_ADDR  = 62,
  parameter int         SEED_ADDR = 63,
  parameter int         OUT_BASE  = 64,
  parameter int         NUM_CHARS = 64,
  parameter logic [7:0] PAD_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [7:0] dm_addr,
  input  logic [7:0] dm_rd_data,
  output logic       dm_wr_en,
  output logic [7:0] dm_wr_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_PRE  = 3'd1,
    LD_TAP  = 3'd2,
    LD_SEED = 3'd3,
    RD      = 3'd4,
    WR      = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       req_q;
  logic [5:0] pre;
  logic [6:0] taps;
  logic [6:0] lfsr;
  logic [6:0] i;
  logic [6:0] pt;

  logic [6:0] src_idx;
  logic       pad;
  logic [6:0] seed_val;
  logic [6:0] ct;
  logic       msb_unused;

  // Plaintext bit 7 plays no part in the ciphertext.
  assign msb_unused = dm_rd_data[7];

  // Source index is only meaningful once i >= pre, so the subtraction cannot
  // wrap in the cases where it is used.
  assign src_idx = i - {1'b0, pre};
  assign pad     = (i < {1'b0, pre}) || (src_idx >= 7'(MSG_MAX));
  assign ct      = pt ^ lfsr;

`ifdef LFSR_ZERO_SEED_GUARD_EN
  assign seed_val = (dm_rd_data[6:0] == 7'd0) ? 7'h01 : dm_rd_data[6:0];
`else
  assign seed_val = dm_rd_data[6:0];
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (init) begin
      state <= IDLE;
      req_q <= 1'b0;
      ack   <= 1'b0;
      pre   <= '0;
      taps  <= '0;
      lfsr  <= '0;
      i     <= '0;
      pt    <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req;
      // ack follows DONE one edge later and drops on the edge req is seen high.
      ack   <= (state == DONE) && !req;
      case (state)
        LD_PRE:  pre  <= dm_rd_data[5:0];
        LD_TAP:  taps <= dm_rd_data[6:0];
        LD_SEED: begin
          lfsr <= seed_val;
          i    <= '0;
        end
        RD:      pt   <= pad ? PAD_CHAR[6:0] : dm_rd_data[6:0];
        WR: begin
          lfsr <= {lfsr[5:0], ^(lfsr & taps)};
          i    <= i + 7'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and DM interface decode.
  always_comb begin
    state_nxt  = state;
    dm_addr    = '0;
    dm_wr_en   = 1'b0;
    dm_wr_data = '0;
    case (state)
      IDLE: begin
        if (req_q && !req) state_nxt = LD_PRE;
      end
      LD_PRE: begin
        dm_addr   = 8'(PRE_ADDR);
        state_nxt = LD_TAP;
      end
      LD_TAP: begin
        dm_addr   = 8'(TAP_ADDR);
        state_nxt = LD_SEED;
      end
      LD_SEED: begin
        dm_addr   = 8'(SEED_ADDR);
        state_nxt = RD;
      end
      RD: begin
        // Padding slots leave the address at 0 so no out-of-message read appears.
        if (!pad) dm_addr = 8'(MSG_BASE) + {1'b0, src_idx};
        state_nxt = WR;
      end
      WR: begin
        dm_addr    = 8'(OUT_BASE) + {1'b0, i};
        dm_wr_en   = 1'b1;
        dm_wr_data = {^ct, ct};
        state_nxt  = (i == 7'(NUM_CHARS - 1)) ? DONE : RD;
      end
      DONE: begin
        if (req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Testbench for lfsr_encrypt_engine: DM model, scoreboard fed by a reference
// model of the encryption rules, directed vector table, randomized runs,
// abort-by-init sequence and DONE/ack handshake checks.

module tb_lfsr_encrypt_engine;

  logic       clk = 1'b0;
  logic       init;
  logic       req;
  logic       ack;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;

  logic [7:0] dm [0:255];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  int checks       = 0;
  int failures     = 0;
  int wr_run_count = 0;
  int cfg_reads    = 0;

  always #5 clk = ~clk;

  assign dm_rd_data = dm[dm_addr];

  lfsr_encrypt_engine dut (
    .clk        (clk),
    .init       (init),
    .req        (req),
    .ack        (ack),
    .dm_addr    (dm_addr),
    .dm_rd_data (dm_rd_data),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_data (dm_wr_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: builds the 64 expected ciphertext bytes from DM contents.
  function automatic void model_run();
    int         pre;
    int         src;
    logic [6:0] taps;
    logic [6:0] s;
    logic [7:0] pt;
    logic [6:0] c;
    pre  = int'(dm[61][5:0]);
    taps = dm[62][6:0];
    s    = dm[63][6:0];
`ifdef LFSR_ZERO_SEED_GUARD_EN
    if (s == 7'd0) s = 7'h01;
`endif
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      src = k - pre;
      if (src < 0 || src >= 61) pt = 8'h20;
      else pt = dm[src];
      c = pt[6:0] ^ s;
      exp_q.push_back(8'(int'(c) + 128 * ($countones(c) % 2)));
      s = 7'((int'(s) * 2 + ($countones(s & taps) % 2)) % 128);
    end
  endfunction

  // DM write port + scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (init === 1'b0) begin
      if (dm_wr_en) begin
        chk("wr_addr", dm_addr, 32'(64 + wr_run_count));
        if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
        else mon_exp = 8'hxx;
        chk("wr_data", dm_wr_data, mon_exp);
        dm[dm_addr] = dm_wr_data;
        wr_run_count++;
      end else begin
        chk("rd_addr_range", dm_addr <= 8'd63, 1);
        if (dm_addr >= 8'd61 && dm_addr <= 8'd63) cfg_reads++;
      end
    end
  end

  task automatic load_text(input string s);
    for (int a = 0; a < 61; a++) dm[a] = 8'h20;
    for (int k = 0; k < s.len(); k++) dm[k] = s[k];
  endtask

  task automatic setup(input logic [7:0] pre_b, input logic [7:0] taps_b, input logic [7:0] seed_b);
    dm[61] = pre_b;
    dm[62] = taps_b;
    dm[63] = seed_b;
    for (int a = 64; a < 128; a++) dm[a] = 8'hEE;
    model_run();
  endtask

  task automatic start_run();
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b1;
    wr_run_count = 0;
    cfg_reads    = 0;
    @(negedge clk); req = 1'b0;
    @(posedge clk);  // start-detect edge
  endtask

  task automatic do_run(input bit toggle);
    int lat;
    start_run();
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      req = (toggle && lat < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
    end while (ack !== 1'b1 && lat < 400);
    chk("ack_latency", lat, 132);
    chk("write_count", wr_run_count, 64);
    chk("cfg_reads", cfg_reads, 3);
    chk("exp_q_left", exp_q.size(), 0);
  endtask

  task automatic finish_run();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ack_hold", ack, 1);
    end
    chk("no_extra_writes", wr_run_count, 64);
    req = 1'b1;
    @(negedge clk);
    chk("ack_drop", ack, 0);
  endtask

  typedef struct {
    logic [7:0] pre;
    logic [7:0] taps;
    logic [7:0] seed;
    logic [7:0] m0;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[9];
  logic [7:0] tap_list[9];

  initial begin
    for (int a = 0; a < 256; a++) dm[a] = 8'h00;
    init = 1'b1;
    req  = 1'b1;

    vt[0] = '{8'd10, 8'h60, 8'h01, 8'h4B, 64, 8'h21};
    vt[1] = '{8'd10, 8'h60, 8'h01, 8'h4B, 65, 8'h22};
    vt[2] = '{8'd10, 8'h60, 8'h01, 8'h4B, 74, 8'h53};
    vt[3] = '{8'd10, 8'h60, 8'h01, 8'h4B, 66, 8'h24};
    vt[4] = '{8'd10, 8'h60, 8'h01, 8'h4B, 69, 8'h00};
    vt[5] = '{8'd10, 8'h60, 8'h01, 8'h4B, 70, 8'hE1};
    // pre byte truncated to 6 bits, seed bit 7 and plaintext bit 7 ignored
    vt[6] = '{8'h4A, 8'h60, 8'h81, 8'hCB, 74, 8'h53};
`ifdef LFSR_ZERO_SEED_GUARD_EN
    vt[7] = '{8'd10, 8'h60, 8'h00, 8'h4B, 64, 8'h21};
    vt[8] = '{8'd10, 8'h60, 8'h00, 8'h4B, 74, 8'h53};
`else
    vt[7] = '{8'd10, 8'h60, 8'h00, 8'h4B, 64, 8'hA0};
    vt[8] = '{8'd10, 8'h60, 8'h00, 8'h4B, 74, 8'h4B};
`endif
    tap_list = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ack", ack, 0);
    chk("reset_wr_en", dm_wr_en, 0);
    chk("reset_addr", dm_addr, 0);
    chk("reset_wr_data", dm_wr_data, 0);
    init = 1'b0;

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      for (int a = 0; a < 61; a++) dm[a] = 8'h20;
      dm[0] = vt[v].m0;
      setup(vt[v].pre, vt[v].taps, vt[v].seed);
      do_run(1'b0);
      finish_run();
      chk($sformatf("vec%0d_dm%0d", v, vt[v].addr), dm[vt[v].addr], vt[v].exp);
    end

    // Every tap pattern, random nonzero seed, pre in 10..26, req toggling mid-run
    for (int t = 0; t < 9; t++) begin
      load_text("Knowledge comes, but wisdom lingers");
      setup(8'($urandom_range(10, 26)), tap_list[t], 8'($urandom_range(1, 127)));
      do_run(1'b1);
      finish_run();
    end

    // pre=26 with a 52-char message
    for (int a = 0; a < 61; a++) dm[a] = (a < 52) ? 8'($urandom_range(33, 126)) : 8'h20;
    setup(8'd26, 8'h78, 8'($urandom_range(1, 127)));
    do_run(1'b0);
    finish_run();

    // Fully random DM, pre=0 first so message slots past 60 must pad
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 61; a++) dm[a] = 8'($urandom_range(0, 255));
      setup((r == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
            tap_list[$urandom_range(0, 8)], 8'($urandom_range(0, 255)));
      do_run(1'b1);
      finish_run();
    end

    // Abort by init during char 30, then a clean rerun
    begin
      int guard;
      load_text("Knowledge comes, but wisdom lingers");
      setup(8'd12, 8'h72, 8'h35);
      start_run();
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!(wr_run_count == 30 && dm_wr_en === 1'b0) && guard < 200);
      chk("abort_reached", wr_run_count, 30);
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      req  = 1'b1;
      chk("abort_wr_en", dm_wr_en, 0);
      chk("abort_ack", ack, 0);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("abort_idle_wr_en", dm_wr_en, 0);
        chk("abort_idle_ack", ack, 0);
      end
      chk("abort_writes", wr_run_count, 30);
      for (int a = 94; a < 128; a++) chk($sformatf("abort_dm%0d", a), dm[a], 8'hEE);
      setup(8'd12, 8'h72, 8'h35);
      do_run(1'b0);
      finish_run();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
